// File: rtl/win_frame.sv
// Multi-channel complex windowing stage ahead of the FFT: 3-stage valid/ready pipeline, runtime-loadable coefficient RAM.
// Optional macro WIN_FRAME_CONVERGENT_ROUND_EN selects round-half-to-even instead of round-half-up.
module win_frame #(
    parameter int unsigned Dwidth = 16,
    parameter int unsigned Cwidth = 16,
    parameter int unsigned Nwin   = 1024,
    parameter int unsigned Iwidth = 10,
    parameter int unsigned Nch    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [Iwidth-1:0]       frame_len_m1,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic [Nch*Dwidth-1:0]   din_real,
    input  logic [Nch*Dwidth-1:0]   din_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sof,
    output logic                    out_eof,
    output logic [Nch*Dwidth-1:0]   dout_real,
    output logic [Nch*Dwidth-1:0]   dout_imag,
    input  logic                    coef_we,
    input  logic [Iwidth-1:0]       coef_addr,
    input  logic [Cwidth-1:0]       coef_wdata
);

    localparam int unsigned Pw = Dwidth + Cwidth + 1;
    localparam int unsigned Vw = Nch * Dwidth;
    localparam int unsigned Lw = Iwidth + 1;
    localparam logic [Iwidth-1:0]      LAST = Iwidth'(Nwin - 1);
    localparam logic [Cwidth-1:0]      HALF = {1'b1, {(Cwidth-1){1'b0}}};
    localparam logic signed [Pw-1:0]   RND  = Pw'(HALF);

    logic              en;
    logic              accept;
    logic [Iwidth-1:0] idx;
    logic [Iwidth-1:0] len_q;
    logic [Iwidth-1:0] len_in_c;
    logic [Iwidth-1:0] idx_use_c;
    logic              eof_c;

    logic [Cwidth-1:0] mem [Nwin] = '{default: '1};

    logic              s1_valid, s1_sof, s1_eof;
    logic [Vw-1:0]     s1_re, s1_im;
    logic [Cwidth-1:0] s1_coef;

    logic              s2_valid, s2_sof, s2_eof;
    logic [Dwidth-1:0] s2_re [Nch];
    logic [Dwidth-1:0] s2_im [Nch];
`ifdef WIN_FRAME_CONVERGENT_ROUND_EN
    logic              s2_tie_re [Nch];
    logic              s2_tie_im [Nch];
`endif

    // Signed sample times unsigned coefficient, rounded half up and truncated to Dwidth.
    function automatic logic [Dwidth-1:0] win_round(input logic [Dwidth-1:0] d, input logic [Cwidth-1:0] c);
        logic signed [Pw-1:0] p;
        p = Pw'(signed'(d)) * Pw'(signed'({1'b0, c}));
        return Dwidth'((p + RND) >>> Cwidth);
    endfunction

`ifdef WIN_FRAME_CONVERGENT_ROUND_EN
    function automatic logic win_tie(input logic [Dwidth-1:0] d, input logic [Cwidth-1:0] c);
        logic signed [Pw-1:0] p;
        p = Pw'(signed'(d)) * Pw'(signed'({1'b0, c}));
        return Cwidth'(p) == HALF;
    endfunction
`endif

    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Clamp the requested length to the RAM depth and resolve this sample's index/eof.
    always_comb begin
        len_in_c  = ({1'b0, frame_len_m1} > Lw'(Nwin - 1)) ? LAST : frame_len_m1;
        idx_use_c = in_sof ? '0 : idx;
        eof_c     = in_sof ? (len_in_c == '0) : (idx == len_q);
    end

    // Index counter advances only on accepted samples; length is re-latched on sof or wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            len_q <= LAST;
        end else if (accept) begin
            if (in_sof) begin
                len_q <= len_in_c;
                idx   <= (len_in_c == '0) ? '0 : Iwidth'(1);
            end else if (idx == len_q) begin
                len_q <= len_in_c;
                idx   <= '0;
            end else begin
                idx   <= idx + Iwidth'(1);
            end
        end
    end

    // Coefficient RAM: registered read returns old data on a same-address write.
    always_ff @(posedge clk) begin
        if (coef_we) mem[coef_addr] <= coef_wdata;
        if (en)      s1_coef        <= mem[idx_use_c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eof    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            dout_real <= '0;
            dout_imag <= '0;
            for (int ch = 0; ch < Nch; ch++) begin
                s2_re[ch] <= '0;
                s2_im[ch] <= '0;
`ifdef WIN_FRAME_CONVERGENT_ROUND_EN
                s2_tie_re[ch] <= 1'b0;
                s2_tie_im[ch] <= 1'b0;
`endif
            end
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_sof    <= in_valid && (idx_use_c == '0);
            s1_eof    <= in_valid && eof_c;
            s1_re     <= din_real;
            s1_im     <= din_imag;
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_eof    <= s1_eof;
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_eof   <= s2_eof;
            for (int ch = 0; ch < Nch; ch++) begin
                s2_re[ch] <= win_round(s1_re[ch*Dwidth +: Dwidth], s1_coef);
                s2_im[ch] <= win_round(s1_im[ch*Dwidth +: Dwidth], s1_coef);
`ifdef WIN_FRAME_CONVERGENT_ROUND_EN
                // A tie already rounded up; clearing the LSB lands on the even neighbour.
                s2_tie_re[ch] <= win_tie(s1_re[ch*Dwidth +: Dwidth], s1_coef);
                s2_tie_im[ch] <= win_tie(s1_im[ch*Dwidth +: Dwidth], s1_coef);
                dout_real[ch*Dwidth +: Dwidth] <= s2_re[ch] & ~Dwidth'(s2_tie_re[ch]);
                dout_imag[ch*Dwidth +: Dwidth] <= s2_im[ch] & ~Dwidth'(s2_tie_im[ch]);
`else
                dout_real[ch*Dwidth +: Dwidth] <= s2_re[ch];
                dout_imag[ch*Dwidth +: Dwidth] <= s2_im[ch];
`endif
            end
        end
    end

endmodule

// File: tb/tb_win_frame.sv
// Directed self-checking bench for win_frame (honours WIN_FRAME_CONVERGENT_ROUND_EN).
module tb_win_frame;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 16;
    localparam int unsigned NW  = 1024;
    localparam int unsigned IW  = 10;
    localparam int unsigned NCH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [IW-1:0]         frame_len_m1;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic [NCH*DW-1:0]     din_real;
    logic [NCH*DW-1:0]     din_imag;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sof;
    logic                  out_eof;
    logic [NCH*DW-1:0]     dout_real;
    logic [NCH*DW-1:0]     dout_imag;
    logic                  coef_we;
    logic [IW-1:0]         coef_addr;
    logic [CW-1:0]         coef_wdata;

    int errors = 0;
    int checks = 0;

    logic signed [15:0] stim_re0 [16];
    logic signed [15:0] stim_im1 [16];
    logic               stim_sof [16];
    logic               cap_v    [16];
    logic signed [15:0] cap_re0  [16];
    logic signed [15:0] cap_im1  [16];
    logic               cap_sof  [16];
    logic               cap_eof  [16];

    win_frame #(.Dwidth(DW), .Cwidth(CW), .Nwin(NW), .Iwidth(IW), .Nch(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .frame_len_m1(frame_len_m1),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .din_real(din_real), .din_imag(din_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .dout_real(dout_real), .dout_imag(dout_imag),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [IW-1:0] a, input logic [CW-1:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        step();
        coef_we    = 1'b0;
    endtask

    task automatic load_ramp();
        write_coef(IW'(0), 16'h4000);
        write_coef(IW'(1), 16'h8000);
        write_coef(IW'(2), 16'hC000);
        write_coef(IW'(3), 16'hFFFF);
    endtask

    // Drives n back-to-back samples with out_ready high and captures each output 3 cycles later.
    task automatic run_stream(input int n);
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                in_valid = 1'b1;
                in_sof   = stim_sof[c];
                din_real = {16'd0, stim_re0[c]};
                din_imag = {stim_im1[c], 16'd0};
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                din_real = '0;
                din_imag = '0;
            end
            step();
            if (c >= 2) begin
                cap_v[c-2]   = out_valid;
                cap_re0[c-2] = dout_real[15:0];
                cap_im1[c-2] = dout_imag[31:16];
                cap_sof[c-2] = out_sof;
                cap_eof[c-2] = out_eof;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_sof !== 1'b0)   begin errors++; $display("FAIL reset_out_sof: got %b expected 0", out_sof); end
        if (out_eof !== 1'b0)   begin errors++; $display("FAIL reset_out_eof: got %b expected 0", out_eof); end
        if (dout_real !== '0)   begin errors++; $display("FAIL reset_dout_real: got %h expected 0", dout_real); end
        if (dout_imag !== '0)   begin errors++; $display("FAIL reset_dout_imag: got %h expected 0", dout_imag); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        step();
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_rect();
        frame_len_m1 = IW'(3);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        din_real = {16'd100, 16'd16384};
        din_imag = {16'hFFFF, 16'hC000};
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        din_real = '0;
        din_imag = '0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rect_early_valid: got %b expected 0", out_valid); end
        step();
        checks += 5;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rect_valid: got %b expected 1", out_valid); end
        if (dout_real !== {16'd100, 16'd16384}) begin errors++; $display("FAIL rect_real: got %h expected %h", dout_real, {16'd100, 16'd16384}); end
        if (dout_imag !== {16'hFFFF, 16'hC000}) begin errors++; $display("FAIL rect_imag: got %h expected ffffc000", dout_imag); end
        if (out_sof !== 1'b1)   begin errors++; $display("FAIL rect_sof: got %b expected 1", out_sof); end
        if (out_eof !== 1'b0)   begin errors++; $display("FAIL rect_eof: got %b expected 0", out_eof); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rect_single: got %b expected 0", out_valid); end
    endtask

    task automatic test_tie_round();
        logic signed [15:0] exp_re [3];
`ifdef WIN_FRAME_CONVERGENT_ROUND_EN
        exp_re[0] = 16'sd0;
`else
        exp_re[0] = 16'sd1;
`endif
        exp_re[1] = 16'sd2;
        exp_re[2] = 16'sd0;
        write_coef(IW'(0), 16'h8000);
        frame_len_m1 = IW'(0);
        stim_re0[0] = 16'sd1;
        stim_re0[1] = 16'sd3;
        stim_re0[2] = -16'sd1;
        for (int k = 0; k < 3; k++) begin
            stim_im1[k] = 16'sd0;
            stim_sof[k] = 1'b1;
        end
        run_stream(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_v[k] !== 1'b1 || cap_re0[k] !== exp_re[k] || cap_sof[k] !== 1'b1 || cap_eof[k] !== 1'b1) begin
                errors++;
                $display("FAIL tie_round[%0d]: got v=%b re=%0d sof=%b eof=%b expected v=1 re=%0d sof=1 eof=1",
                         k, cap_v[k], cap_re0[k], cap_sof[k], cap_eof[k], exp_re[k]);
            end
        end
    endtask

    task automatic test_frame();
        load_ramp();
        frame_len_m1 = IW'(3);
        for (int k = 0; k < 10; k++) begin
            stim_re0[k] = 16'sd4;
            stim_im1[k] = -16'sd4;
            stim_sof[k] = (k == 0);
        end
        run_stream(10);
        // Coefficients 0.25/0.5/0.75/~1 scale 4 to 1/2/3/4 and -4 to -1/-2/-3/-4.
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (cap_v[k] !== 1'b1 || cap_re0[k] !== 16'(k % 4 + 1) || cap_im1[k] !== 16'(-(k % 4 + 1))
                || cap_sof[k] !== (k % 4 == 0) || cap_eof[k] !== (k % 4 == 3)) begin
                errors++;
                $display("FAIL frame[%0d]: got v=%b re=%0d im=%0d sof=%b eof=%b expected v=1 re=%0d im=%0d sof=%b eof=%b",
                         k, cap_v[k], cap_re0[k], cap_im1[k], cap_sof[k], cap_eof[k],
                         k % 4 + 1, -(k % 4 + 1), (k % 4 == 0), (k % 4 == 3));
            end
        end
    endtask

    task automatic test_sof_truncate();
        int exp_idx [7];
        exp_idx = '{0, 1, 0, 1, 2, 3, 0};
        frame_len_m1 = IW'(3);
        for (int k = 0; k < 7; k++) begin
            stim_re0[k] = 16'sd4;
            stim_im1[k] = 16'sd0;
            stim_sof[k] = (k == 0) || (k == 2);
        end
        run_stream(7);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cap_v[k] !== 1'b1 || cap_re0[k] !== 16'(exp_idx[k] + 1)
                || cap_sof[k] !== (exp_idx[k] == 0) || cap_eof[k] !== (exp_idx[k] == 3)) begin
                errors++;
                $display("FAIL sof_truncate[%0d]: got v=%b re=%0d sof=%b eof=%b expected v=1 re=%0d sof=%b eof=%b",
                         k, cap_v[k], cap_re0[k], cap_sof[k], cap_eof[k],
                         exp_idx[k] + 1, (exp_idx[k] == 0), (exp_idx[k] == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        logic stalled = 1'b0;
        logic [NCH*DW-1:0] held_re = '0;
        logic held_sof = 1'b0;
        logic held_eof = 1'b0;
        for (int a = 0; a < 4; a++) write_coef(IW'(a), 16'hFFFF);
        frame_len_m1 = IW'(3);
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (tx < 8);
            in_sof    = (tx == 0);
            din_real  = {16'd0, 16'(10 + tx)};
            din_imag  = '0;
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready, !(out_valid && !out_ready));
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || dout_real !== held_re || out_sof !== held_sof || out_eof !== held_eof) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d: got v=%b re=%h sof=%b eof=%b expected v=1 re=%h sof=%b eof=%b",
                             cyc, out_valid, dout_real, out_sof, out_eof, held_re, held_sof, held_eof);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (dout_real[15:0] !== 16'(10 + rx) || out_sof !== (rx % 4 == 0) || out_eof !== (rx % 4 == 3)) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got re=%0d sof=%b eof=%b expected re=%0d sof=%b eof=%b",
                             rx, dout_real[15:0], out_sof, out_eof, 10 + rx, (rx % 4 == 0), (rx % 4 == 3));
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            stalled  = out_valid && !out_ready;
            held_re  = dout_real;
            held_sof = out_sof;
            held_eof = out_eof;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 8) begin errors++; $display("FAIL bp_count: got %0d samples expected 8", rx); end
    endtask

    task automatic test_reset_midstream();
        load_ramp();
        frame_len_m1 = IW'(3);
        din_imag = '0;
        din_real = {16'd0, 16'd4};
        in_valid = 1'b1;
        in_sof   = 1'b1;
        step();
        in_sof   = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        din_real = '0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", out_valid); end
        if (dout_real[15:0] !== 16'd1) begin errors++; $display("FAIL rst_pre_data: got %0d expected 1", dout_real[15:0]); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        if (out_sof !== 1'b0)   begin errors++; $display("FAIL rst_async_sof: got %b expected 0", out_sof); end
        if (dout_real !== '0)   begin errors++; $display("FAIL rst_async_dout: got %h expected 0", dout_real); end
        step();
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush cyc %0d: got %b expected 0", c, out_valid); end
        end
        stim_re0[0] = 16'sd4;
        stim_im1[0] = -16'sd4;
        stim_sof[0] = 1'b0;
        run_stream(1);
        checks++;
        if (cap_v[0] !== 1'b1 || cap_re0[0] !== 16'sd1 || cap_im1[0] !== -16'sd1 || cap_sof[0] !== 1'b1 || cap_eof[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: got v=%b re=%0d im=%0d sof=%b eof=%b expected v=1 re=1 im=-1 sof=1 eof=0",
                     cap_v[0], cap_re0[0], cap_im1[0], cap_sof[0], cap_eof[0]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_len_m1 = IW'(3);
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        din_real     = '0;
        din_imag     = '0;
        out_ready    = 1'b1;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_wdata   = '0;
        test_reset();
        test_rect();
        test_tie_round();
        test_frame();
        test_sof_truncate();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/win_frame.md
Name: win_frame

Overview:
- Parametrised, multi-channel complex windowing stage that sits ahead of the FFT in the spectral datapath.
- Multiplies each accepted sample by a window coefficient and rounds the result.
- Coefficients live in a runtime-loadable RAM and are indexed by an internal sample counter with programmable frame length.
- Full valid/ready backpressure; frame start/end markers travel with the data.

Parameters:
- Dwidth, 16, sample component width (signed two's complement).
- Cwidth, 16, coefficient width (unsigned Q0.Cwidth; value = coef/2^Cwidth).
- Nwin, 1024, coefficient RAM depth = maximum frame length.
- Iwidth, 10, index width; must equal clog2(Nwin).
- Nch, 2, number of complex channels sharing one coefficient per sample.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_len_m1  in  Iwidth  frame length minus 1; sampled only when the counter wraps or sof_in is accepted.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input ready.
- in_sof  in  1  forces this sample to index 0.
- din_real  in  Nch*Dwidth  packed real parts, channel 0 in the LSBs.
- din_imag  in  Nch*Dwidth  packed imaginary parts, same packing.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_sof  out  1  output sample was index 0.
- out_eof  out  1  output sample was index frame_len_m1.
- dout_real  out  Nch*Dwidth  windowed real parts.
- dout_imag  out  Nch*Dwidth  windowed imaginary parts.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  Iwidth  coefficient write address.
- coef_wdata  in  Cwidth  coefficient write data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_sof=0, out_eof=0, dout_*=0, index counter=0, latched frame length=Nwin-1, all pipeline valids=0. Coefficient RAM is not reset; it is power-up initialised to 2^Cwidth-1 (rectangular window).
- Handshake:
  - Transfer occurs when valid && ready on a port.
  - Global pipeline enable en = out_ready || !out_valid; in_ready = en.
  - When en=0 every stage holds. out_valid/out_sof/out_eof/dout_* are stable while out_valid && !out_ready.
- Pipeline: 3 stages.
  - S1 registers data, reads coef RAM at the current index, and registers sof/eof.
  - S2 computes the multiply plus round constant.
  - S3 registers the output.
  - Latency is 3 en-cycles: a sample accepted at cycle t appears at t+3 with no stall.
  - Pipeline bubbles propagate as valid=0 and do not advance the index.
- Index counter (advances only on an accepted input):
  - in_sof=1: the sample uses index 0, and the next index is 1, or 0 if frame_len_m1==0. frame_len_m1 is latched at this point.
  - Otherwise, index==latched_len: the sample is flagged eof and the next index is 0. frame_len_m1 is re-latched on the wrap.
  - Otherwise index+1.
  - out_sof marks samples at index 0; out_eof marks samples at index latched_len. Both are set on the same sample when the length is 1.
  - in_sof arriving mid-frame truncates the frame: no eof is emitted for the truncated frame.
  - frame_len_m1 >= Nwin is clamped to Nwin-1.
- Arithmetic, per channel and component:
  - p = signed(din) * signed({1'b0,coef}), width Dwidth+Cwidth+1.
  - dout = (p + 2^(Cwidth-1)) >>> Cwidth, i.e. round half up, keeping the low Dwidth bits.
  - No overflow is possible since coef < 2^Cwidth.
- Coefficient RAM: single write port, one read port.
  - A write is visible to reads issued the following cycle.
  - A read and write to the same address in the same cycle returns the old data.
  - Writes are accepted regardless of stall state.

Optional Feature:
- Macro WIN_FRAME_CONVERGENT_ROUND_EN.
- Defined: ties (low Cwidth bits of p exactly 2^(Cwidth-1)) round to even, i.e. the result LSB is forced to 0; other values round to nearest. Latency is unchanged.
- Undefined: round half up as above.

Test Plan:
- Reset, then a rectangular window (coef 0xFFFF), din_real ch0=16384, 1 sample -> dout_real ch0=16384 at 3 cycles after acceptance, out_sof=1.
- Tie rounding: coef[0]=0x8000 written, din=1, 3, -1 -> 1, 2, 0 without the macro; 0, 2, 0 with WIN_FRAME_CONVERGENT_ROUND_EN.
- frame_len_m1=3, 10 continuous samples -> out_sof on samples 0, 4, 8; out_eof on samples 3, 7; coefficients used cycle 0,1,2,3,0,1,2,3,0,1.
- Backpressure: out_ready toggles 1,0,0,1 with continuous input -> no sample lost or duplicated, outputs stable while stalled, in_ready==0 exactly while out_valid && !out_ready.
- in_sof asserted at index 2 of a length-4 frame -> that sample uses coef[0] and carries out_sof=1; no out_eof is emitted for the truncated frame.
- rst_n asserted mid-stream with 2 samples in flight -> out_valid drops immediately, the in-flight samples are discarded, and the first sample after release uses index 0.
